// File: rtl/instr_encoder_if.sv
// ---------------------------------------------------------------------------
// instr_encoder_if
//   Request and response bundle for the RV32I instruction encoder.
//
//   Request side (loader -> encoder):
//     in_valid, in_ready        valid/ready handshake
//     fmt                       0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6/7 illegal
//     opcode, rd, rs1, rs2,     decoded instruction fields
//     funct3, funct7, imm       (imm is two's complement, byte units)
//   Response side (encoder -> image writer):
//     out_valid, out_ready      valid/ready handshake
//     out_instr                 encoded 32-bit instruction word
//     out_addr                  byte address of out_instr
//     out_err                   word is a substituted NOP after an encode error
//
//   master: the side that produces requests and consumes encoded words.
//   slave:  the encoder itself.
// ---------------------------------------------------------------------------
interface instr_encoder_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            fmt;
  logic [6:0]            opcode;
  logic [4:0]            rd;
  logic [4:0]            rs1;
  logic [4:0]            rs2;
  logic [2:0]            funct3;
  logic [6:0]            funct7;
  logic [31:0]           imm;
  logic                  out_valid;
  logic                  out_ready;
  logic [31:0]           out_instr;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic                  out_err;

  modport master (
    output in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, out_err
  );

  modport slave (
    input  in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr, out_err
  );
endinterface

// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//   Streaming RV32I instruction encoder (inverse of an immediate generator).
//   Accepts decoded fields, range-checks the immediate, scatters it into the
//   bit positions of the selected format and presents the 32-bit word with its
//   target byte address through a single output register stage.
//
//   Ports:
//     clk        rising-edge clock
//     rst        synchronous reset, active-high; drops any held word
//     clear      synchronous; out_addr -> START_ADDR, err_count -> 0,
//                a held word stays valid
//     bus        instr_encoder_if.slave request/response bundle
//     err_count  saturating count of errored words handed to the consumer
//
//   START_ADDR must be 4-aligned; every emitted word (including substituted
//   NOPs) occupies one 4-byte slot so the image layout stays aligned.
// ---------------------------------------------------------------------------
module instr_encoder #(
  parameter int                    ADDR_WIDTH    = 32,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR    = '0,
  parameter int                    ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  instr_encoder_if.slave           bus,
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  // ADDI x0, x0, 0 -- emitted in place of any word that fails its checks.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic                     valid_q, valid_d;
  logic [31:0]              instr_q, instr_d;
  logic                     err_q, err_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

  logic        accept;
  logic        out_hs;
  logic [31:0] enc_instr;
  logic        enc_err;
  logic        fits_12;
  logic        fits_13;
  logic        fits_21;

  // The output register may be refilled when empty or when it is being
  // drained in this very cycle.
  assign bus.in_ready = !valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign out_hs       = valid_q && bus.out_ready;

  // An N-bit signed value fits when every bit from the sign position upward
  // is identical (all zeros or all ones).
  assign fits_12 = (&bus.imm[31:11]) || !(|bus.imm[31:11]);
  assign fits_13 = (&bus.imm[31:12]) || !(|bus.imm[31:12]);
  assign fits_21 = (&bus.imm[31:20]) || !(|bus.imm[31:20]);

  // -------------------------------------------------------------------------
  // Field packing and immediate checks
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path through
    // the case can leave it unassigned and infer a latch.
    enc_instr = NOP_INSTR;
    enc_err   = 1'b0;

    case (fmt_e'(bus.fmt))
      FMT_R: begin
        enc_instr = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
      end
      FMT_I: begin
        enc_instr = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
        enc_err   = !fits_12;
      end
      FMT_S: begin
        enc_instr = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3,
                     bus.imm[4:0], bus.opcode};
        enc_err   = !fits_12;
      end
      FMT_B: begin
        // Branch offsets are half-word granular; bit 0 is not encodable.
        enc_instr = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                     bus.imm[4:1], bus.imm[11], bus.opcode};
        enc_err   = !fits_13 || bus.imm[0];
      end
      FMT_U: begin
        // Only the upper 20 bits are encodable; any low bit set is lost.
        enc_instr = {bus.imm[31:12], bus.rd, bus.opcode};
        enc_err   = |bus.imm[11:0];
      end
      FMT_J: begin
        enc_instr = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12],
                     bus.rd, bus.opcode};
        enc_err   = !fits_21 || bus.imm[0];
      end
      default: begin
        enc_err = 1'b1;
      end
    endcase

    if (enc_err) begin
      enc_instr = NOP_INSTR;
    end
  end

  // -------------------------------------------------------------------------
  // Output register next-state
  // -------------------------------------------------------------------------
  always_comb begin
    valid_d   = valid_q;
    instr_d   = instr_q;
    err_d     = err_q;
    addr_d    = addr_q;
    err_cnt_d = err_cnt_q;

    if (out_hs) begin
      valid_d = 1'b0;
      addr_d  = addr_q + ADDR_WIDTH'(4);
      if (err_q && (err_cnt_q != '1)) begin
        err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
      end
    end

    // A same-cycle accept refills the stage, so out_valid stays high.
    if (accept) begin
      valid_d = 1'b1;
      instr_d = enc_instr;
      err_d   = enc_err;
    end

    // clear wins over the handshake increments but leaves the held word alone.
    if (clear) begin
      addr_d    = START_ADDR;
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignment so every flop samples the
    // pre-edge value of every other flop, independent of statement order.
    if (rst) begin
      valid_q   <= 1'b0;
      instr_q   <= '0;
      err_q     <= 1'b0;
      addr_q    <= START_ADDR;
      err_cnt_q <= '0;
    end else begin
      valid_q   <= valid_d;
      instr_q   <= instr_d;
      err_q     <= err_d;
      addr_q    <= addr_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_instr = instr_q;
  assign bus.out_err   = err_q;
  assign bus.out_addr  = addr_q;
  assign err_count     = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder
//   Directed bench for instr_encoder. A behavioural model (spec-level packing
//   tables, signed range checks, an expected address and error tally) is
//   compared against the DUT every cycle; literal values computed by hand
//   from the RV32I encodings pin both the model and the DUT.
// ---------------------------------------------------------------------------
module tb_instr_encoder;

  localparam int          AW      = 32;
  localparam int          CW      = 16;
  localparam logic [31:0] START   = 32'h0;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic          clk;
  logic          rst;
  logic          clear;
  logic [CW-1:0] err_count;

  int n_cmp  = 0;
  int n_fail = 0;

  instr_encoder_if #(.ADDR_WIDTH(AW)) bus ();

  instr_encoder #(
    .ADDR_WIDTH   (AW),
    .START_ADDR   (START),
    .ERR_CNT_WIDTH(CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .bus      (bus),
    .err_count(err_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Spec-level reference: returns {err, word}.
  function automatic logic [32:0] model_encode(
    input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd_,
    input logic [4:0] rs1_, input logic [4:0] rs2_, input logic [2:0] f3,
    input logic [6:0] f7, input logic [31:0] im);
    int          s;
    logic [31:0] w;
    bit          bad;
    s   = im;
    w   = '0;
    bad = 1'b0;
    case (f)
      3'd0: w = {f7, rs2_, rs1_, f3, rd_, op};
      3'd1: begin
        bad = (s < -2048) || (s > 2047);
        w   = {im[11:0], rs1_, f3, rd_, op};
      end
      3'd2: begin
        bad = (s < -2048) || (s > 2047);
        w   = {im[11:5], rs2_, rs1_, f3, im[4:0], op};
      end
      3'd3: begin
        bad = (s < -4096) || (s > 4094) || im[0];
        w   = {im[12], im[10:5], rs2_, rs1_, f3, im[4:1], im[11], op};
      end
      3'd4: begin
        bad = (im[11:0] != 12'd0);
        w   = {im[31:12], rd_, op};
      end
      3'd5: begin
        bad = (s < -1048576) || (s > 1048574) || im[0];
        w   = {im[20], im[10:1], im[11], im[19:12], rd_, op};
      end
      default: bad = 1'b1;
    endcase
    return bad ? {1'b1, NOP} : {1'b0, w};
  endfunction

  // Compare process: checks the DUT against the model, then advances the
  // model with the inputs that the next rising edge will see.
  initial begin : compare
    logic          m_valid = 1'b0;
    logic [31:0]   m_instr = '0;
    logic          m_err   = 1'b0;
    logic [AW-1:0] m_addr  = START;
    logic [CW-1:0] m_cnt   = '0;
    logic          acc;
    logic          hs;
    logic [32:0]   enc;
    forever begin
      @(negedge clk);
      check("mdl_out_valid", 32'(bus.out_valid), 32'(m_valid));
      check("mdl_in_ready", 32'(bus.in_ready), 32'(!m_valid || bus.out_ready));
      check("mdl_out_addr", bus.out_addr, m_addr);
      check("mdl_err_count", 32'(err_count), 32'(m_cnt));
      if (m_valid) begin
        check("mdl_out_instr", bus.out_instr, m_instr);
        check("mdl_out_err", 32'(bus.out_err), 32'(m_err));
      end

      if (rst) begin
        m_valid = 1'b0;
        m_instr = '0;
        m_err   = 1'b0;
        m_addr  = START;
        m_cnt   = '0;
      end else begin
        acc = bus.in_valid && (!m_valid || bus.out_ready);
        hs  = m_valid && bus.out_ready;
        if (hs) begin
          m_addr = m_addr + 4;
          if (m_err && m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
        end
        if (clear) begin
          m_addr = START;
          m_cnt  = '0;
        end
        if (acc) begin
          enc     = model_encode(bus.fmt, bus.opcode, bus.rd, bus.rs1, bus.rs2,
                                 bus.funct3, bus.funct7, bus.imm);
          m_valid = 1'b1;
          m_err   = enc[32];
          m_instr = enc[31:0];
        end else if (hs) begin
          m_valid = 1'b0;
        end
      end
    end
  end

  task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd_,
                       input logic [4:0] rs1_, input logic [4:0] rs2_, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] im);
    bus.in_valid = 1'b1;
    bus.fmt      = f;
    bus.opcode   = op;
    bus.rd       = rd_;
    bus.rs1      = rs1_;
    bus.rs2      = rs2_;
    bus.funct3   = f3;
    bus.funct7   = f7;
    bus.imm      = im;
  endtask

  // Returns 1 time unit after the edge that accepted the pending request.
  task automatic wait_accept();
    logic acc = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
  endtask

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  vec_t vecs [12];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    vecs[0]  = '{3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'hDEADBEEF, 32'h002081B3, 1'b0};
    vecs[1]  = '{3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'h0,        32'h402081B3, 1'b0};
    vecs[2]  = '{3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd1, 7'h00, 32'hFFFFFFF8, 32'hFE209CE3, 1'b0};
    vecs[3]  = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2047,     32'h7FF00093, 1'b0};
    vecs[4]  = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048,     NOP,          1'b1};
    vecs[5]  = '{3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'hFFFFF7FF, NOP,          1'b1};
    vecs[6]  = '{3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd4094,     32'h7E000FE3, 1'b0};
    vecs[7]  = '{3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd4096,     NOP,          1'b1};
    vecs[8]  = '{3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd1048574,  32'h7FFFF06F, 1'b0};
    vecs[9]  = '{3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFF00000, 32'h8000006F, 1'b0};
    vecs[10] = '{3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd1048576,  NOP,          1'b1};
    vecs[11] = '{3'd6, 7'h13, 5'd1, 5'd1, 5'd1, 3'd0, 7'h00, 32'd0,        NOP,          1'b1};

    rst           = 1'b1;
    clear         = 1'b0;
    bus.out_ready = 1'b0;
    drive(3'd0, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, 32'h0);
    bus.in_valid  = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_instr", bus.out_instr, 32'h0);
    check("rst_out_err", 32'(bus.out_err), 32'd0);
    check("rst_out_addr", bus.out_addr, START);
    check("rst_err_count", 32'(err_count), 32'd0);
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.out_ready = 1'b1;

    // ADDI x1, x0, -1
    drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'hFFFFFFFF);
    wait_accept();
    bus.in_valid = 1'b0;
    #1;
    check("addi_valid", 32'(bus.out_valid), 32'd1);
    check("addi_instr", bus.out_instr, 32'hFFF00093);
    check("addi_addr", bus.out_addr, 32'h0);
    check("addi_err", 32'(bus.out_err), 32'd0);
    @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    #1;
    check("clear1_addr", bus.out_addr, START);

    // Back-to-back: SW then JAL
    drive(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h0, 32'd4);
    wait_accept();
    drive(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'd8);
    #1;
    check("sw_instr", bus.out_instr, 32'h0020A223);
    check("sw_addr", bus.out_addr, 32'h0);
    check("sw_in_ready", 32'(bus.in_ready), 32'd1);
    wait_accept();
    bus.in_valid = 1'b0;
    #1;
    check("jal_instr", bus.out_instr, 32'h008000EF);
    check("jal_addr", bus.out_addr, 32'h4);
    check("jal_in_ready", 32'(bus.in_ready), 32'd1);

    // LUI legal, then with a dropped low bit
    drive(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h0, 32'h12345000);
    wait_accept();
    bus.in_valid = 1'b0;
    #1;
    check("lui_instr", bus.out_instr, 32'h123452B7);
    check("lui_addr", bus.out_addr, 32'h8);
    drive(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h0, 32'h12345001);
    wait_accept();
    bus.in_valid = 1'b0;
    #1;
    check("luierr_instr", bus.out_instr, NOP);
    check("luierr_err", 32'(bus.out_err), 32'd1);
    check("luierr_cnt_before", 32'(err_count), 32'd0);
    @(posedge clk);
    #1;
    check("luierr_cnt_after", 32'(err_count), 32'd1);
    check("luierr_addr_after", bus.out_addr, 32'h10);

    // Backpressure with a queued request
    bus.out_ready = 1'b0;
    drive(3'd1, 7'h13, 5'd2, 5'd1, 5'd0, 3'd0, 7'h0, 32'd5);
    wait_accept();
    drive(3'd1, 7'h13, 5'd3, 5'd2, 5'd0, 3'd0, 7'h0, 32'hFFFFF800);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_valid", 32'(bus.out_valid), 32'd1);
      check("bp_instr", bus.out_instr, 32'h00508113);
      check("bp_addr", bus.out_addr, 32'h10);
      @(posedge clk);
      #2;
    end
    bus.out_ready = 1'b1;
    wait_accept();
    bus.in_valid = 1'b0;
    #1;
    check("bp_next_instr", bus.out_instr, 32'h80010193);
    check("bp_next_addr", bus.out_addr, 32'h14);
    check("bp_next_valid", 32'(bus.out_valid), 32'd1);

    // Boundary vector table
    foreach (vecs[i]) begin
      drive(vecs[i].fmt, vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
            vecs[i].f3, vecs[i].f7, vecs[i].imm);
      wait_accept();
      bus.in_valid = 1'b0;
      #1;
      check($sformatf("vec%0d_instr", i), bus.out_instr, vecs[i].exp_instr);
      check($sformatf("vec%0d_err", i), 32'(bus.out_err), 32'(vecs[i].exp_err));
    end
    @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;

    // Two error NOPs back-to-back: odd branch offset, illegal format
    drive(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h0, 32'd3);
    wait_accept();
    drive(3'd7, 7'h13, 5'd1, 5'd1, 5'd1, 3'd0, 7'h0, 32'd0);
    #1;
    check("berr_instr", bus.out_instr, NOP);
    check("berr_err", 32'(bus.out_err), 32'd1);
    check("berr_addr", bus.out_addr, 32'h0);
    wait_accept();
    bus.in_valid = 1'b0;
    #1;
    check("ferr_instr", bus.out_instr, NOP);
    check("ferr_err", 32'(bus.out_err), 32'd1);
    check("ferr_cnt_mid", 32'(err_count), 32'd1);
    check("ferr_addr", bus.out_addr, 32'h4);
    @(posedge clk);
    #1;
    check("two_err_cnt", 32'(err_count), 32'd2);
    check("two_err_addr", bus.out_addr, 32'h8);

    // clear
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    #1;
    check("clear2_cnt", 32'(err_count), 32'd0);
    check("clear2_addr", bus.out_addr, START);

    // clear keeps a held word; rst drops it
    drive(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'h0);
    wait_accept();
    drive(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'h0);
    wait_accept();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    check("held_addr", bus.out_addr, 32'h4);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    #1;
    check("clr_held_valid", 32'(bus.out_valid), 32'd1);
    check("clr_held_instr", bus.out_instr, 32'h402081B3);
    check("clr_held_addr", bus.out_addr, START);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_mid_valid", 32'(bus.out_valid), 32'd0);
    check("rst_mid_addr", bus.out_addr, START);

    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Streaming RISC-V RV32I instruction encoder; the inverse of the immediate generator.
- Takes decoded fields (format, opcode, registers, functs, 32-bit immediate) over a valid/ready handshake.
- Range-checks the immediate, scatters it into the format's bit positions and emits a 32-bit instruction word with its target byte address.
- Used by the test/boot loader to build instruction memory images in-system.

Parameters:
- ADDR_WIDTH, 32, width of out_addr.
- START_ADDR, 0, byte address of the first emitted word; must be 4-aligned.
- ERR_CNT_WIDTH, 16, width of the saturating error counter.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  request valid.
- in_ready  out  1  encoder can accept a request this cycle.
- fmt  in  3  format: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6/7 illegal.
- opcode  in  7  placed verbatim in bits [6:0].
- rd  in  5  destination register.
- rs1  in  5  source register 1.
- rs2  in  5  source register 2.
- funct3  in  3  funct3 field.
- funct7  in  7  funct7 field (R only).
- imm  in  32  immediate, two's complement, byte units.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  consumer accepts the word.
- out_instr  out  32  encoded instruction.
- out_addr  out  ADDR_WIDTH  byte address of out_instr.
- out_err  out  1  this word is a substituted NOP due to an encode error.
- err_count  out  ERR_CNT_WIDTH  saturating count of errored words emitted.
- clear  in  1  synchronous: resets out_addr to START_ADDR and err_count to 0; does not drop the held word.

Behaviour:
- Reset values: out_valid=0, out_instr=0, out_err=0, out_addr=START_ADDR, err_count=0.
- Output register stage: in_ready = !out_valid || out_ready (combinational).
- Accept occurs when in_valid && in_ready. The encoded word is registered and out_valid=1 on the next cycle; latency is 1.
- Full throughput is 1 word/cycle when out_ready is held high.
- While out_valid && !out_ready: out_instr, out_addr and out_err hold stable, and in_ready=0.
- Output handshake is out_valid && out_ready. On a handshake, out_addr += 4 (wraps modulo 2^ADDR_WIDTH) and out_valid drops unless a new accept happens the same cycle.
- Simultaneous handshake plus accept loads the new word with out_valid staying 1.
- Packing per format:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}.
  - I: {imm[11:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - U: {imm[31:12], rd, opcode}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
- Error checks, evaluated at accept:
  - I/S: imm outside [-2048, 2047].
  - B: imm outside [-4096, 4094] or imm[0]=1.
  - J: imm outside [-1048576, 1048574] or imm[0]=1.
  - U: imm[11:0] != 0.
  - Illegal fmt.
  - R never errors; imm is ignored.
- On error: out_instr = 0x00000013 (ADDI x0,x0,0) and out_err=1. The word still occupies an address, so the image stays aligned.
- err_count increments on the output handshake of an errored word and saturates at all-ones.
- clear has priority over the increments in the same cycle.
- rst mid-transfer drops any held word; the consumer sees out_valid=0 on the next cycle.

Test Plan:
- Reset, then I-type opcode 0x13, rd=1, rs1=0, funct3=0, imm=-1 -> out_instr 0xFFF00093, out_addr 0x0, out_err 0, one cycle after accept.
- Back-to-back with out_ready=1:
  - S opcode 0x23, funct3=2, rs1=1, rs2=2, imm=4 -> 0x0020A223 at addr 0x0.
  - Then J opcode 0x6F, rd=1, imm=8 -> 0x008000EF at addr 0x4; in_ready stays 1.
- U opcode 0x37, rd=5, imm=0x12345000 -> 0x123452B7.
- Same U with imm=0x12345001 -> 0x00000013, out_err=1, err_count=1 after the handshake.
- Backpressure: hold out_ready=0 for 3 cycles after a valid word -> in_ready=0, outputs stable. Release -> handshake, addr advances by 4, the next queued request is accepted the same cycle.
- B-type imm=3 and fmt=7 -> two NOPs with out_err=1, err_count=2.
- Then clear -> err_count=0, out_addr=START_ADDR.
- Assert rst while out_valid=1 and out_ready=0 -> out_valid=0 next cycle, out_addr=START_ADDR.
